pulse_sync_detect: RTL and testbench

- Single-clock input conditioner for an asynchronous level/pulse input `pulse`.
- Input passes through a multi-flop synchronizer, then a rising-edge detector.
- Each detected edge produces a fixed-width, registered output pulse on `out` and increments an event counter.
- Sits at the boundary where an external or foreign-domain strobe enters the `clk` domain.

---
 rtl/pulse_sync_detect.sv | 62 ++++++
 tb/tb_pulse_sync_detect.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/pulse_sync_detect.sv
// Multi-flop synchronizer + edge detector that emits a stretched OUT_W-cycle strobe per edge.
// Define PULSE_SYNC_BOTH_EDGES_EN to detect falling as well as rising input transitions.
`timescale 1ns/1ps
module pulse_sync_detect #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned OUT_W       = 1,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pulse,
  output logic             out,
  output logic             busy,
  output logic [CNT_W-1:0] event_cnt
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   prev;
  logic                   s;
  logic                   detect;
  logic [7:0]             width_cnt;

  assign s = sync[SYNC_STAGES-1];

`ifdef PULSE_SYNC_BOTH_EDGES_EN
  assign detect = s ^ prev;
`else
  assign detect = s & ~prev;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pulse};
      prev <= s;
    end
  end

  // A detect while out is already high reloads the width, so back-to-back strobes merge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 1'b0;
      width_cnt <= '0;
      event_cnt <= '0;
    end else if (detect) begin
      out       <= 1'b1;
      width_cnt <= 8'(OUT_W - 1);
      event_cnt <= event_cnt + CNT_W'(1);
    end else if (out) begin
      if (width_cnt != '0) begin
        width_cnt <= width_cnt - 8'd1;
      end else begin
        out <= 1'b0;
      end
    end
  end

  assign busy = out;

endmodule

// File: tb/tb_pulse_sync_detect.sv
// Randomized scoreboard bench for pulse_sync_detect; two parameterizations share one input.
`timescale 1ns/1ps
module tb_pulse_sync_detect;

  localparam int unsigned S0 = 2, W0 = 1, C0 = 8;
  localparam int unsigned S1 = 3, W1 = 4, C1 = 2;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          pulse = 1'b0;
  logic          out0, busy0, out1, busy1;
  logic [C0-1:0] cnt0;
  logic [C1-1:0] cnt1;

  pulse_sync_detect #(.SYNC_STAGES(S0), .OUT_W(W0), .CNT_W(C0)) dut0 (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .out(out0), .busy(busy0), .event_cnt(cnt0)
  );

  pulse_sync_detect #(.SYNC_STAGES(S1), .OUT_W(W1), .CNT_W(C1)) dut1 (
    .clk(clk), .rst_n(rst_n), .pulse(pulse), .out(out1), .busy(busy1), .event_cnt(cnt1)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          o;
    int unsigned c;
  } exp_t;

  exp_t        q0[$];
  exp_t        q1[$];
  bit          samp[$];   // input value seen at each clk edge since the last reset release
  int unsigned mcnt0, mcnt1;
  int unsigned checks   = 0;
  int unsigned failures = 0;
  bit          done     = 1'b0;

  // An input change recorded at sample index i counts as one event.
  function automatic bit is_evt(int i);
    bit p;
    p = (i == 0) ? 1'b0 : samp[i-1];
`ifdef PULSE_SYNC_BOTH_EDGES_EN
    return samp[i] != p;
`else
    return samp[i] && !p;
`endif
  endfunction

  // Strobe is high for W edges starting S edges after the sampled event.
  function automatic bit out_exp(int n, int s, int w);
    for (int k = 0; k < w; k++) begin
      if (n - s - k >= 0 && is_evt(n - s - k)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic model_edge(input bit v);
    int   n;
    exp_t e;
    samp.push_back(v);
    n = samp.size() - 1;
    if (n >= int'(S0) && is_evt(n - int'(S0))) mcnt0++;
    if (n >= int'(S1) && is_evt(n - int'(S1))) mcnt1++;
    e.o = out_exp(n, int'(S0), int'(W0));
    e.c = mcnt0 % (1 << C0);
    q0.push_back(e);
    e.o = out_exp(n, int'(S1), int'(W1));
    e.c = mcnt1 % (1 << C1);
    q1.push_back(e);
  endtask

  task automatic step(input bit v, input bit rel);
    exp_t z;
    z.o = 1'b0;
    z.c = 0;
    @(negedge clk);
    pulse = v;
    if (rel) rst_n = 1'b1;
    if (rst_n) begin
      model_edge(v);
    end else begin
      q0.push_back(z);
      q1.push_back(z);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    samp.delete();
    mcnt0 = 0;
    mcnt1 = 0;
  endtask

  function automatic void chk(string name, int unsigned act, int unsigned exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  initial begin : monitor
    bit   r_prev;
    exp_t e;
    r_prev = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      if (!rst_n && r_prev) begin
        chk("async_rst_out0", 32'(out0), 0);
        chk("async_rst_busy0", 32'(busy0), 0);
        chk("async_rst_cnt0", 32'(cnt0), 0);
        chk("async_rst_out1", 32'(out1), 0);
        chk("async_rst_busy1", 32'(busy1), 0);
        chk("async_rst_cnt1", 32'(cnt1), 0);
      end else begin
        if (q0.size() > 0) begin
          e = q0.pop_front();
          chk("out0", 32'(out0), 32'(e.o));
          chk("busy0", 32'(busy0), 32'(e.o));
          chk("event_cnt0", 32'(cnt0), e.c);
        end
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("out1", 32'(out1), 32'(e.o));
          chk("busy1", 32'(busy1), 32'(e.o));
          chk("event_cnt1", 32'(cnt1), e.c);
        end
      end
      r_prev = rst_n;
      if (done) begin
        chk("queue_drain", q0.size() + q1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    logic [15:0] retrig;
    int unsigned len;
    bit          lvl;
    mcnt0 = 0;
    mcnt1 = 0;
    retrig = 16'b0000_0000_1110_1000;  // LSB first: edges two cycles apart

    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Async reset while dut1's strobe is active, input still high at release.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0);

    // Long high/low periods.
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      for (int i = 0; i < 6; i++) step(1'b0, 1'b0);
    end

    for (int i = 0; i < 16; i++) step(retrig[i], 1'b0);

    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 300; c += int'(len)) begin
        len = $urandom_range(1, 8);
        lvl = 1'($urandom_range(0, 1));
        for (int k = 0; k < int'(len); k++) step(lvl, 1'b0);
      end
      if (seg == 1) begin
        do_reset();
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
      end
    end

    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
    done = 1'b1;
  end

endmodule
